// File: rtl/gate_vector_checker.sv
// gate_vector_checker: walks every N_IN-bit input vector onto a combinational
// gate, holds it SETTLE_CYCLES cycles, samples y and checks it against OP.
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   start, abort    begin a run (IDLE/DONE only), cancel a run in progress
//   in_vec, y       vector driven to the gate, gate output under check
//   busy, done      run in progress, run complete (held until next start)
//   pass            done with zero mismatches
//   err_count       saturating mismatch count for the current run
//   mismatch_*      one-cycle report of a failing vector and its sampled y
module gate_vector_checker #(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 10,
    parameter int OP            = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] in_vec,
    input  logic            y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [7:0]      err_count,
    output logic            mismatch_valid,
    output logic [N_IN-1:0] mismatch_vec,
    output logic            mismatch_y
);

    // Counter must still exist when SETTLE_CYCLES is 1 (it only ever holds 0).
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      err_q, err_d;
    logic            mv_q, mv_d;
    logic [N_IN-1:0] mvec_q, mvec_d;
    logic            my_q, my_d;

    logic            expect_y;
    logic            last_vec;
    logic            mism;

    always_comb begin
        expect_y = 1'b0;
        case (OP)
            0:       expect_y = &vec_q;
            1:       expect_y = |vec_q;
            default: expect_y = ^vec_q;
        endcase
    end

    assign last_vec = &vec_q;
    assign mism     = (y != expect_y);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks both the settle countdown and a
    // same-edge sample.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (abort)            state_d = S_IDLE;
                else if (cnt_q == '0) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort)         state_d = S_IDLE;
                else if (last_vec) state_d = S_DONE;
                else               state_d = S_SETTLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        busy = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
        done = (state_q == S_DONE);
    end

    assign pass = done && (err_q == 8'd0);

    // Datapath next-state
    always_comb begin
        vec_d  = vec_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        mv_d   = 1'b0;
        mvec_d = mvec_q;
        my_d   = my_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    vec_d = '0;
                    cnt_d = CNT_INIT;
                    err_d = 8'd0;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    vec_d = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    vec_d = '0;
                end else begin
                    if (mism) begin
                        mv_d   = 1'b1;
                        mvec_d = vec_q;
                        my_d   = y;
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    end
                    // The last vector stays on the gate while DONE.
                    if (!last_vec) begin
                        vec_d = vec_q + N_IN'(1);
                        cnt_d = CNT_INIT;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 8'd0;
            mv_q   <= 1'b0;
            mvec_q <= '0;
            my_q   <= 1'b0;
        end else begin
            vec_q  <= vec_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            mv_q   <= mv_d;
            mvec_q <= mvec_d;
            my_q   <= my_d;
        end
    end

    assign in_vec         = vec_q;
    assign err_count      = err_q;
    assign mismatch_valid = mv_q;
    assign mismatch_vec   = mvec_q;
    assign mismatch_y     = my_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: a 2-input AND instance with fault-injected
// gate models and a 9-input XOR instance driven by an inverted gate.
module tb_gate_vector_checker;

    localparam int N1  = 2;
    localparam int SC1 = 10;
    localparam int P1  = SC1 + 1;
    localparam int L1  = (1 << N1) * P1;
    localparam int N2  = 9;
    localparam int SC2 = 1;
    localparam int P2  = SC2 + 1;
    localparam int L2  = (1 << N2) * P2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start1, abort1, start2, abort2;

    logic [N1-1:0] vec1, mvec1;
    logic          y1, busy1, done1, pass1, mv1, my1;
    logic [7:0]    err1;

    logic [N2-1:0] vec2, mvec2;
    logic          y2, busy2, done2, pass2, mv2, my2;
    logic [7:0]    err2;

    int checks = 0;
    int errors = 0;

    // Gate model for instance 1: 0 good AND, 1 stuck-0, 2 stuck-1,
    // 3 good AND with random per-vector output flips.
    int mode = 0;
    bit flip[4];

    gate_vector_checker #(.N_IN(N1), .SETTLE_CYCLES(SC1), .OP(0)) u_and (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .in_vec(vec1), .y(y1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .mismatch_valid(mv1), .mismatch_vec(mvec1),
        .mismatch_y(my1)
    );

    gate_vector_checker #(.N_IN(N2), .SETTLE_CYCLES(SC2), .OP(2)) u_xor (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .in_vec(vec2), .y(y2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .mismatch_valid(mv2), .mismatch_vec(mvec2),
        .mismatch_y(my2)
    );

    always_comb begin
        case (mode)
            0:       y1 = ($countones(vec1) == N1);
            1:       y1 = 1'b0;
            2:       y1 = 1'b1;
            default: y1 = ($countones(vec1) == N1) ^ flip[vec1];
        endcase
    end

    assign y2 = ($countones(vec2) % 2) == 0;

    function automatic bit and_ideal(input int v);
        return $countones(v) == N1;
    endfunction

    function automatic bit gate1_ref(input int v);
        case (mode)
            0:       return and_ideal(v);
            1:       return 1'b0;
            2:       return 1'b1;
            default: return and_ideal(v) ^ flip[v];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // t = cycles since the start-accepting edge, sampled 1 time unit after it.
    task automatic check1(input int t, input bit mis[4]);
        int e;
        int k;
        bit emv;
        e = 0;
        for (int i = 0; i < 4; i++)
            if ((i + 1) * P1 <= t && mis[i]) e++;
        if (e > 255) e = 255;
        chk("vec1", vec1, (t < L1) ? t / P1 : 3);
        chk("busy1", busy1, t < L1);
        chk("done1", done1, t >= L1);
        chk("err1", err1, e);
        chk("pass1", pass1, (t >= L1) && (e == 0));
        emv = 0;
        k = 0;
        if (t > 0 && t % P1 == 0 && t <= L1) begin
            k = t / P1 - 1;
            emv = mis[k];
        end
        chk("mv1", mv1, emv);
        if (emv) begin
            chk("mvec1", mvec1, k);
            chk("my1", my1, gate1_ref(k));
        end
    endtask

    task automatic prep(input int m, output bit mis[4]);
        mode = m;
        for (int i = 0; i < 4; i++) flip[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 4; i++) mis[i] = gate1_ref(i) != and_ideal(i);
    endtask

    task automatic pulse_start1();
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
    endtask

    task automatic run1(input int m);
        bit mis[4];
        prep(m, mis);
        pulse_start1();
        for (int t = 0; t <= L1 + 2; t++) begin
            check1(t, mis);
            @(posedge clk); #1;
        end
    endtask

    task automatic run_abort();
        bit mis[4];
        prep(2, mis);
        pulse_start1();
        for (int t = 0; t < 15; t++) begin
            check1(t, mis);
            start1 = (t == 4);
            abort1 = (t == 14);
            @(posedge clk); #1;
        end
        abort1 = 1'b0;
        start1 = 1'b0;
        chk("ab_vec", vec1, 0);
        chk("ab_busy", busy1, 0);
        chk("ab_done", done1, 0);
        chk("ab_err", err1, 1);
        chk("ab_mv", mv1, 0);
        chk("ab_pass", pass1, 0);
        @(posedge clk); #1;
        chk("ab_idle", busy1, 0);
        chk("ab_vec2", vec1, 0);
    endtask

    task automatic check_reset1(input string tag);
        chk({tag, "_vec"}, vec1, 0);
        chk({tag, "_busy"}, busy1, 0);
        chk({tag, "_done"}, done1, 0);
        chk({tag, "_pass"}, pass1, 0);
        chk({tag, "_err"}, err1, 0);
        chk({tag, "_mv"}, mv1, 0);
        chk({tag, "_mvec"}, mvec1, 0);
        chk({tag, "_my"}, my1, 0);
    endtask

    task automatic run_reset();
        bit mis[4];
        prep(2, mis);
        pulse_start1();
        for (int t = 0; t < 30; t++) begin
            check1(t, mis);
            rst_n = (t != 29);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        check_reset1("mrst");
    endtask

    task automatic run_xor();
        int pulses;
        int e;
        int k;
        pulses = 0;
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        for (int t = 0; t <= L2 + 1; t++) begin
            chk("vec2", vec2, (t < L2) ? t / P2 : (1 << N2) - 1);
            chk("busy2", busy2, t < L2);
            e = (t / P2 < (1 << N2)) ? t / P2 : (1 << N2);
            if (e > 255) e = 255;
            chk("err2", err2, e);
            if (t > 0 && t % P2 == 0 && t <= L2) begin
                k = t / P2 - 1;
                chk("mv2", mv2, 1);
                chk("mvec2", mvec2, k);
                chk("my2", my2, ($countones(k) % 2) == 0);
            end else begin
                chk("mv2", mv2, 0);
            end
            if (mv2) pulses++;
            if (t == L2 - 1) chk("done2_early", done2, 0);
            if (t == L2) chk("done2", done2, 1);
            @(posedge clk); #1;
        end
        chk("pulses2", pulses, 1 << N2);
        chk("err2_sat", err2, 255);
        chk("pass2", pass2, 0);
        chk("done2_hold", done2, 1);
    endtask

    initial begin
        rst_n  = 1'b0;
        start1 = 1'b0;
        abort1 = 1'b0;
        start2 = 1'b0;
        abort2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset1("rst");
        chk("rst_vec2", vec2, 0);
        chk("rst_busy2", busy2, 0);
        chk("rst_done2", done2, 0);
        chk("rst_err2", err2, 0);
        rst_n = 1'b1;

        run1(0);
        run1(1);
        run1(2);
        run1(0);
        run_abort();
        run1(0);
        run_reset();
        run1(0);
        repeat (4) run1(3);
        run1(1);
        run_xor();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_vector_checker.md
# gate_vector_checker

Synthesizable exhaustive-stimulus and checking stage that sits directly upstream and downstream of a small combinational gate block through its interface signals. It walks every input combination, drives it onto the gate inputs, waits a programmable settle time, then samples the gate output. It compares each sample against the expected Boolean function and reports mismatches, an error count, and a final pass/fail. It replaces delay-based testbench sequencing with a clocked, repeatable sequence.

## Interface
Parameters:
- N_IN, 2: number of gate inputs; vectors span 0 .. 2^N_IN-1; legal range 1..9.
- SETTLE_CYCLES, 10: cycles each vector is held before sampling; must be ≥1.
- OP, 0: expected function; 0=AND (&vec), 1=OR (|vec), 2=XOR (^vec).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  reset; synchronous and active-low, sampled on the clk rising edge.
- start  input  1  begin a run; honoured only in IDLE or DONE.
- abort  input  1  cancel a run in progress.
- in_vec  output  N_IN  drives gate inputs; for N_IN=2, a=in_vec[1] and b=in_vec[0].
- y  input  1  gate output under check.
- busy  output  1  high in SETTLE or SAMPLE.
- done  output  1  high in DONE; held until the next accepted start or a reset.
- pass  output  1  done && (err_count==0).
- err_count  output  8  mismatches in the current run; saturates at 255.
- mismatch_valid  output  1  one-cycle pulse per mismatch.
- mismatch_vec  output  N_IN  vector that mismatched; valid with mismatch_valid, otherwise holds its last value.
- mismatch_y  output  1  sampled y at the mismatch.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE, start=1 at an edge:
  - in_vec←0, cnt←SETTLE_CYCLES-1, err_count←0, done←0.
  - Next state is SETTLE.
- SETTLE: in_vec held constant.
  - If cnt≠0, cnt decrements.
  - If cnt==0, next state is SAMPLE.
- SAMPLE, one cycle:
  - y is compared against expected(in_vec).
  - On mismatch: mismatch_valid=1 in the next cycle, mismatch_vec←in_vec, mismatch_y←y, err_count increments (no wrap past 255).
  - If in_vec is all ones, next state is DONE; otherwise in_vec increments, cnt←SETTLE_CYCLES-1, and next state is SETTLE.
- abort=1 in SETTLE or SAMPLE: next state is IDLE, in_vec←0, done stays 0, err_count is retained. abort has priority over a same-edge SAMPLE compare; that compare is discarded. abort in IDLE or DONE has no effect.
- start while busy is ignored. start and abort both high while busy: abort wins and start is ignored.
- In DONE, in_vec holds the all-ones vector.

## Timing
- Reset values: state=IDLE, in_vec=0, busy=0, done=0, pass=0, err_count=0, mismatch_valid=0, mismatch_vec=0, mismatch_y=0.
- Reset mid-run forces the reset values at the next edge and discards any pending mismatch pulse.
- Edge E0 is the one that accepts start. Vector k is driven from edge E0+k·(SETTLE_CYCLES+1).
- y for vector k is sampled at edge E0+k·(SETTLE_CYCLES+1)+SETTLE_CYCLES+1.
- done rises at edge E0+2^N_IN·(SETTLE_CYCLES+1); busy falls at the same edge.
- mismatch_valid and the err_count update appear one cycle after the SAMPLE-state edge, together.
- For the last vector they appear in the same cycle done rises.
- pass is combinational from the registered done and err_count, so it is valid in the same cycle done rises.
- The gate must settle within SETTLE_CYCLES clock periods. The checker applies no extra synchronisation to y.

## Test plan
- Correct AND gate, N_IN=2, SETTLE_CYCLES=10, OP=0, start pulse → in_vec steps 0,1,2,3, each held 11 cycles; done at E0+44; pass=1; err_count=0; mismatch_valid never pulses.
- y stuck at 0, OP=0 → exactly one mismatch_valid pulse with mismatch_vec=3 and mismatch_y=0; err_count=1; pass=0.
- y stuck at 1, OP=0 → pulses for vectors 0,1,2; err_count=3. Then restart with a correct gate → err_count clears to 0 at E0 and the run ends with pass=1.
- abort asserted at E0+15 (vector 1, SETTLE) → IDLE at the next edge; in_vec=0; busy=0; done=0. A start pulsed at E0+5 earlier in that run is ignored.
- rst_n low for one edge at E0+30 → all outputs at reset values on the following cycle. A following start runs a full 44-cycle sequence.
- N_IN=9, SETTLE_CYCLES=1, y inverted → err_count saturates at 255; mismatch_valid pulses 512 times; done at E0+1024.
